// File: rtl/scan_key_pkg.sv
// scan_key_pkg: shared FSM state type and default key width for scan_key_tx.
package scan_key_pkg;
  localparam int KEY_WIDTH_DEF = 16;
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY, DONE} state_t;
endpackage

// File: rtl/scan_key_tx_if.sv
// scan_key_tx_if: key handshake plus serial scan-chain outputs; master drives keys, slave is the shifter.
interface scan_key_tx_if import scan_key_pkg::*; #(parameter int KEY_WIDTH = KEY_WIDTH_DEF) ();
  logic                 key_valid;
  logic                 key_ready;
  logic [KEY_WIDTH-1:0] key_data;
  logic                 scan_en;
  logic                 scan_out;
  logic                 scan_done;
  logic                 busy;
  modport master (output key_valid, key_data, input key_ready, scan_en, scan_out, scan_done, busy);
  modport slave (input key_valid, key_data, output key_ready, scan_en, scan_out, scan_done, busy);
endinterface

// File: rtl/scan_shift_reg.sv
// scan_shift_reg: load/shift-right key register with registered serial output.
// SCAN_PARITY_EN adds a running even-parity accumulator selectable onto the serial output.
module scan_shift_reg #(parameter int KEY_WIDTH = 16) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_load,
  input  logic                 i_shift,
`ifdef SCAN_PARITY_EN
  input  logic                 i_par_sel,
`endif
  input  logic [KEY_WIDTH-1:0] i_data,
  output logic                 o_out
);
  logic [KEY_WIDTH-1:0] r_sr;
  logic                 r_out;
  logic                 w_par_out;
`ifdef SCAN_PARITY_EN
  logic r_par;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_par <= 1'b0;
    else r_par <= i_load ? i_data[0] : i_shift ? r_par ^ r_sr[0] : r_par;
  assign w_par_out = i_par_sel & r_par;
`else
  assign w_par_out = 1'b0;
`endif
  // bit 0 goes straight to the output on load, so r_sr keeps only the bits still to send
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_sr  <= '0;
      r_out <= 1'b0;
    end else begin
      r_sr  <= i_load ? {1'b0, i_data[KEY_WIDTH-1:1]} : i_shift ? r_sr >> 1 : r_sr;
      r_out <= i_load ? i_data[0] : i_shift ? r_sr[0] : w_par_out;
    end
  assign o_out = r_out;
endmodule

// File: rtl/scan_key_tx.sv
// scan_key_tx: accepts a parallel key and shifts it LSB first into a scan chain, then pulses scan_done.
// Define SCAN_PARITY_EN to append one even-parity bit after the key bits.
module scan_key_tx import scan_key_pkg::*; #(parameter int KEY_WIDTH = KEY_WIDTH_DEF) (
  input logic           clk,
  input logic           rst,
  scan_key_tx_if.slave  bus
);
  localparam int CW = $clog2(KEY_WIDTH + 1);
`ifdef SCAN_PARITY_EN
  localparam state_t AFTER_SHIFT = PARITY;
`else
  localparam state_t AFTER_SHIFT = DONE;
`endif
  state_t        r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic          w_accept, w_last;
  logic          r_key_ready, r_scan_en, r_scan_done, r_busy;
  logic          w_key_ready, w_scan_en, w_scan_done, w_busy;
  assign w_accept = (r_state == IDLE) & bus.key_valid;
  assign w_last   = (r_state == SHIFT) & (r_cnt == CW'(KEY_WIDTH - 1));
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_key_ready <= 1'b1;
      r_scan_en   <= 1'b0;
      r_scan_done <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_cnt       <= w_accept ? '0 : (r_state == SHIFT) ? r_cnt + CW'(1) : r_cnt;
      r_key_ready <= w_key_ready;
      r_scan_en   <= w_scan_en;
      r_scan_done <= w_scan_done;
      r_busy      <= w_busy;
    end
  always_comb
    w_next = (r_state == IDLE)   ? (bus.key_valid ? SHIFT : IDLE) :
             (r_state == SHIFT)  ? (w_last ? AFTER_SHIFT : SHIFT) :
             (r_state == PARITY) ? DONE : IDLE;
  // outputs are decoded from the next state so the registered copies line up with the state
  always_comb begin
    w_key_ready = (w_next == IDLE);
    w_scan_en   = (w_next == SHIFT) | (w_next == PARITY);
    w_scan_done = (w_next == DONE);
    w_busy      = (w_next != IDLE);
  end
  scan_shift_reg #(.KEY_WIDTH(KEY_WIDTH)) u_sr (
    .clk       (clk),
    .rst       (rst),
    .i_load    (w_accept),
    .i_shift   ((r_state == SHIFT) & ~w_last),
`ifdef SCAN_PARITY_EN
    .i_par_sel (w_last),
`endif
    .i_data    (bus.key_data),
    .o_out     (bus.scan_out)
  );
  assign bus.key_ready = r_key_ready;
  assign bus.scan_en   = r_scan_en;
  assign bus.scan_done = r_scan_done;
  assign bus.busy      = r_busy;
endmodule

// File: doc/scan_key_tx.md
SCAN_KEY_TX -- requirements
Module: scan_key_tx

Interface
REQ-001 SHALL provide parameter KEY_WIDTH, default 16, number of key bits shifted per transfer (legal range 2..256).
REQ-002 SHALL provide port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL provide port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL provide port key_valid  input  1  upstream offers key_data.
REQ-005 SHALL provide port key_ready  output  1  block can accept a key.
REQ-006 SHALL provide port key_data  input  KEY_WIDTH  parallel key word, bit 0 shifted first.
REQ-007 SHALL provide port scan_en  output  1  high while scan_out carries a valid chain bit.
REQ-008 SHALL provide port scan_out  output  1  serial bit into the downstream scan/key chain.
REQ-009 SHALL provide port scan_done  output  1  one-cycle pulse after the last bit.
REQ-010 SHALL provide port busy  output  1  high from acceptance until the scan_done cycle inclusive.

Function
REQ-011 SHALL implement states IDLE, SHIFT, PARITY, DONE; all outputs registered.
REQ-012 In IDLE: key_ready=1, scan_en=0, scan_out=0, busy=0.
REQ-013 Handshake: key accepted on the edge where key_valid && key_ready; key_data captured into shift register, bit counter cleared, next state SHIFT.
REQ-014 key_ready SHALL be 0 in SHIFT, PARITY and DONE; key_valid in those states is ignored and not latched.
REQ-015 SHIFT: first bit appears on scan_out, with scan_en=1, in the cycle after acceptance; one bit per cycle, LSB first, exactly KEY_WIDTH cycles.
REQ-016 Bit counter width SHALL be clog2(KEY_WIDTH+1); on count reaching KEY_WIDTH-1 the next state is PARITY if enabled, else DONE.
REQ-017 key_data changes after acceptance SHALL NOT affect the bits shifted.
REQ-018 DONE: scan_en=0, scan_out=0, scan_done=1 for exactly one cycle, busy=1; next state IDLE.
REQ-019 Back-to-back: a key offered during DONE is not accepted; earliest next acceptance is the first IDLE cycle (turnaround KEY_WIDTH+2 cycles minimum without parity).

Reset
REQ-020 rst asserted SHALL immediately force IDLE, key_ready=1 (after release), scan_en=0, scan_out=0, scan_done=0, busy=0, counter=0, shift register=0.
REQ-021 rst mid-transfer SHALL abort with no scan_done pulse; partial chain contents are not the block's responsibility.

Configuration
REQ-022 With macro SCAN_PARITY_EN defined, PARITY state SHALL follow SHIFT for one cycle, driving scan_en=1 and scan_out=XOR of all KEY_WIDTH key bits (even parity).
REQ-023 Without SCAN_PARITY_EN, PARITY state and parity logic SHALL be absent; SHIFT goes directly to DONE.

Structure
REQ-024 A shared package scan_key_pkg SHALL hold the state enum type and the default KEY_WIDTH constant.
REQ-025 One sub-module scan_shift_reg (load, shift-right, serial out, running parity) SHALL be instantiated; FSM and counter stay in scan_key_tx.

Verification (KEY_WIDTH=8)
REQ-026 Key 0xA5 accepted at cycle 0 -> scan_out 1,0,1,0,0,1,0,1 with scan_en=1 on cycles 1..8, scan_done=1 on cycle 9 (no parity), key_ready=1 on cycle 10.
REQ-027 SCAN_PARITY_EN: 0xA5 -> parity bit 0 on cycle 9, scan_done cycle 10; 0x07 -> parity bit 1.
REQ-028 key_valid held high with 0x3C then 0xC3 -> two complete transfers, second accepted in first IDLE cycle after scan_done, no bits dropped or duplicated.
REQ-029 rst pulsed at cycle 4 of a 0xFF transfer -> scan_en=0, busy=0 same cycle, no scan_done; next key 0x01 shifts 1,0,0,0,0,0,0,0 correctly.
REQ-030 key_valid pulsed with 0x55 during SHIFT of 0xAA -> ignored; only 0xAA bits observed, key_ready stays 0 until IDLE.
